pc_fetch_unit: RTL and testbench

- Program-counter and next-PC stage of the single-cycle MIPS core. It sits directly upstream of CPU_Control.
- Holds the PC register and drives the fetch address to instruction memory.
- Supplies the supervisor bit (PC[31]) and a synchronised, gated interrupt request to CPU_Control.
- Each cycle, computes the next PC from CPU_Control's PCSrc, the branch outcome, JT, Imm16 and the rs register value. Captures the exception return address on trap entry.

---
 rtl/pc_fetch_unit.sv | 117 +++++++++++
 tb/tb_pc_fetch_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter, next-PC select, EPC capture and the
// synchronised, edge-detected, mode-gated interrupt request for the
// single-cycle MIPS core. Bit 31 of the PC is the supervisor (kernel) bit.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h8000_0000,
    parameter logic [31:0] ILLOP_VEC = 32'h8000_0004,
    parameter logic [31:0] XADR_VEC  = 32'h8000_0008
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [2:0]  PCSrc,
    input  logic        branch_taken,
    input  logic [25:0] JT,
    input  logic [15:0] Imm16,
    input  logic [31:0] rs_data,
    input  logic        irq_req,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        kernel,
    output logic        irq,
    output logic [31:0] epc
);

    localparam logic [2:0] SRC_SEQ   = 3'd0;
    localparam logic [2:0] SRC_BR    = 3'd1;
    localparam logic [2:0] SRC_J     = 3'd2;
    localparam logic [2:0] SRC_JR    = 3'd3;
    localparam logic [2:0] SRC_ILLOP = 3'd4;

    logic [31:0] pc_q, pc_d;
    logic [31:0] epc_q, epc_d;
    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        edge_q, edge_d;
    logic        pend_q, pend_d;

    logic [30:0] imm_off;
    logic [31:0] conba;
    logic [31:0] npc_raw;
    logic        irq_rise;
    logic        irq_clear;

    // Sequential and branch-target arithmetic: the adds are 31 bits wide so
    // the supervisor bit is never changed by an increment or offset.
    always_comb begin
        pc_plus4 = {pc_q[31], pc_q[30:0] + 31'd4};
        imm_off  = {{13{Imm16[15]}}, Imm16, 2'b00};
        conba    = {pc_q[31], pc_plus4[30:0] + imm_off};
    end

    // Next-PC select; user-mode jr is stripped of bit 31 so it cannot enter
    // kernel space, and word alignment is forced on every path.
    always_comb begin
        npc_raw = XADR_VEC;
        case (PCSrc)
            SRC_SEQ:   npc_raw = pc_plus4;
            SRC_BR:    npc_raw = branch_taken ? conba : pc_plus4;
            SRC_J:     npc_raw = {pc_q[31:28], JT, 2'b00};
            SRC_JR:    npc_raw = pc_q[31] ? rs_data : {1'b0, rs_data[30:0]};
            SRC_ILLOP: npc_raw = ILLOP_VEC;
            default:   npc_raw = XADR_VEC;
        endcase
        pc_d = stall ? pc_q : {npc_raw[31:2], 2'b00};
    end

    // EPC: interrupts return to the interrupted instruction, illegal ops
    // return past the faulting instruction.
    always_comb begin
        epc_d = epc_q;
        if (!stall) begin
            if (PCSrc == SRC_ILLOP)
                epc_d = pc_q;
            else if (PCSrc > SRC_ILLOP)
                epc_d = pc_plus4;
        end
    end

    // Interrupt path: 2-flop synchroniser plus edge register run every cycle;
    // a new edge always wins over a same-cycle acknowledge so it is not lost.
    always_comb begin
        sync1_d   = irq_req;
        sync2_d   = sync1_q;
        edge_d    = sync2_q;
        irq_rise  = sync2_q & ~edge_q;
        irq_clear = (PCSrc == SRC_ILLOP) & ~stall & ~pc_q[31];
        pend_d    = irq_rise | (pend_q & ~irq_clear);
    end

    // State registers with synchronous active-low reset dominating stall.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            epc_q   <= 32'h0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            edge_q  <= edge_d;
            pend_q  <= pend_d;
        end
    end

    // Outputs straight from registers; irq is masked while in kernel mode.
    always_comb begin
        pc     = pc_q;
        epc    = epc_q;
        kernel = pc_q[31];
        irq    = pend_q & ~pc_q[31];
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed walk through the fetch, branch, jump,
// trap and interrupt scenarios followed by a randomized run, all checked
// against a behavioural model of the PC/EPC/interrupt rules.
module tb_pc_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h8000_0000;
    localparam logic [31:0] ILLOP_VEC = 32'h8000_0004;
    localparam logic [31:0] XADR_VEC  = 32'h8000_0008;
    localparam logic [31:0] MSB       = 32'h8000_0000;
    localparam logic [31:0] LOW31     = 32'h7FFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [2:0]  PCSrc;
    logic        branch_taken;
    logic [25:0] JT;
    logic [15:0] Imm16;
    logic [31:0] rs_data;
    logic        irq_req;
    logic [31:0] pc, pc_plus4, epc;
    logic        kernel, irq;

    int checks = 0;
    int failures = 0;

    // Model state: architectural PC/EPC, pending flag, and the last three
    // irq_req samples (index 0 = most recent).
    logic [31:0] m_pc, m_epc;
    logic        m_pend;
    logic        hist [$];

    pc_fetch_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .PCSrc(PCSrc),
        .branch_taken(branch_taken), .JT(JT), .Imm16(Imm16),
        .rs_data(rs_data), .irq_req(irq_req), .pc(pc), .pc_plus4(pc_plus4),
        .kernel(kernel), .irq(irq), .epc(epc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_plus4(input logic [31:0] p);
        return (p & MSB) | ((p + 32'd4) & LOW31);
    endfunction

    // One rising edge of the reference behaviour using the current inputs.
    task automatic model_edge();
        logic [31:0] nxt, p4, off;
        logic rise, clr;
        if (!reset) begin
            m_pc = RESET_PC; m_epc = 0; m_pend = 0;
            hist = '{1'b0, 1'b0, 1'b0};
            return;
        end
        rise = hist[1] && !hist[2];
        clr  = 1'b0;
        p4   = m_plus4(m_pc);
        if (!stall) begin
            off = 32'($signed(Imm16)) * 32'd4;
            case (PCSrc)
                3'd0: nxt = p4;
                3'd1: nxt = branch_taken ? ((m_pc & MSB) | ((m_pc + 32'd4 + off) & LOW31)) : p4;
                3'd2: nxt = (m_pc & 32'hF000_0000) | (32'(JT) * 32'd4);
                3'd3: nxt = m_pc[31] ? rs_data : (rs_data & LOW31);
                3'd4: nxt = ILLOP_VEC;
                default: nxt = XADR_VEC;
            endcase
            if (PCSrc == 3'd4) begin
                m_epc = m_pc;
                clr = !m_pc[31];
            end else if (PCSrc >= 3'd5) begin
                m_epc = p4;
            end
            m_pc = nxt & ~32'd3;
        end
        m_pend = rise || (m_pend && !clr);
        hist.push_front(irq_req);
        void'(hist.pop_back());
    endtask

    // Apply inputs, clock once, then compare every output with the model.
    task automatic step(input logic rst, input logic stl, input logic [2:0] src,
                        input logic bt, input logic [25:0] jt, input logic [15:0] imm,
                        input logic [31:0] rs, input logic req);
        reset = rst; stall = stl; PCSrc = src; branch_taken = bt;
        JT = jt; Imm16 = imm; rs_data = rs; irq_req = req;
        @(posedge clk);
        model_edge();
        #1;
        chk("pc", pc, m_pc);
        chk("pc_plus4", pc_plus4, m_plus4(m_pc));
        chk("kernel", 32'(kernel), 32'(m_pc[31]));
        chk("irq", 32'(irq), 32'(m_pend && !m_pc[31]));
        chk("epc", epc, m_epc);
    endtask

    task automatic run(input logic [2:0] src, input logic [31:0] rs, input logic req);
        step(1'b1, 1'b0, src, 1'b0, 26'h0, 16'h0, rs, req);
    endtask

    initial begin
        m_pc = 0; m_epc = 0; m_pend = 0;
        hist = '{1'b0, 1'b0, 1'b0};

        // Reset then free run.
        step(1'b0, 1'b0, 3'd0, 1'b0, 26'h0, 16'h0, 32'h0, 1'b0);
        chk("rst_pc", pc, 32'h8000_0000);
        chk("rst_epc", epc, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        run(3'd0, 32'h0, 1'b0);
        chk("seq1", pc, 32'h8000_0004);
        run(3'd0, 32'h0, 1'b0);
        chk("seq2", pc, 32'h8000_0008);
        chk("seq_kernel", 32'(kernel), 32'h1);

        // Branch taken / not taken from 0000_0100 with offset -2 words.
        run(3'd3, 32'h0000_0100, 1'b0);
        step(1'b1, 1'b0, 3'd1, 1'b1, 26'h0, 16'hFFFE, 32'h0, 1'b0);
        chk("br_taken", pc, 32'h0000_00FC);
        run(3'd3, 32'h0000_0100, 1'b0);
        step(1'b1, 1'b0, 3'd1, 1'b0, 26'h0, 16'hFFFE, 32'h0, 1'b0);
        chk("br_not", pc, 32'h0000_0104);

        // Jump and user-mode jr.
        run(3'd3, 32'h0040_0000, 1'b0);
        step(1'b1, 1'b0, 3'd2, 1'b0, 26'h000_0010, 16'h0, 32'h0, 1'b0);
        chk("j", pc, 32'h0000_0040);
        run(3'd3, 32'h8000_1000, 1'b0);
        chk("jr_user", pc, 32'h0000_1000);

        // Kernel-mode jr, including the return to user space.
        run(3'd5, 32'h0, 1'b0);
        run(3'd3, 32'h8000_0100, 1'b0);
        chk("jr_k0", pc, 32'h8000_0100);
        run(3'd3, 32'h8000_1000, 1'b0);
        chk("jr_k1", pc, 32'h8000_1000);
        run(3'd3, 32'h0000_2000, 1'b0);
        chk("jr_k2", pc, 32'h0000_2000);

        // Interrupt: raise at 0000_0200 and observe the 3-cycle latency.
        run(3'd3, 32'h0000_0200, 1'b0);
        run(3'd3, 32'h0000_0200, 1'b1);
        chk("irq_t1", 32'(irq), 32'h0);
        run(3'd3, 32'h0000_0200, 1'b1);
        chk("irq_t2", 32'(irq), 32'h0);
        run(3'd3, 32'h0000_0200, 1'b1);
        chk("irq_t3", 32'(irq), 32'h1);
        run(3'd4, 32'h0, 1'b1);
        chk("trap_pc", pc, 32'h8000_0004);
        chk("trap_epc", epc, 32'h0000_0200);
        chk("trap_irq", 32'(irq), 32'h0);
        for (int i = 0; i < 10; i++) run(3'd0, 32'h0, 1'b1);
        run(3'd3, 32'h0000_0300, 1'b0);
        chk("held_once", 32'(irq), 32'h0);

        // Fresh edge while in kernel is held until return to user.
        run(3'd5, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) run(3'd0, 32'h0, 1'b1);
        chk("kern_mask", 32'(irq), 32'h0);
        run(3'd3, 32'h0000_0400, 1'b0);
        chk("kern_ret", 32'(irq), 32'h1);

        // Acknowledge coinciding with a new edge keeps pending set.
        run(3'd0, 32'h0, 1'b1);
        run(3'd0, 32'h0, 1'b0);
        run(3'd4, 32'h0, 1'b0);
        run(3'd3, 32'h0000_0500, 1'b0);
        chk("setclr", 32'(irq), 32'h1);

        // Illegal op, stall, reset under stall.
        run(3'd4, 32'h0, 1'b0);
        run(3'd3, 32'h0000_0300, 1'b0);
        run(3'd5, 32'h0, 1'b0);
        chk("xadr_pc", pc, 32'h8000_0008);
        chk("xadr_epc", epc, 32'h0000_0304);
        step(1'b1, 1'b1, 3'd2, 1'b0, 26'h3FF_FFFF, 16'h0, 32'h0, 1'b0);
        chk("stall_pc", pc, 32'h8000_0008);
        step(1'b0, 1'b1, 3'd4, 1'b0, 26'h0, 16'h0, 32'h0, 1'b0);
        chk("rst_stall_pc", pc, 32'h8000_0000);
        chk("rst_stall_epc", epc, 32'h0);

        // Randomized run.
        for (int i = 0; i < 600; i++) begin
            logic r, s, b, q;
            r = ($urandom_range(0, 59) != 0);
            s = ($urandom_range(0, 3) == 0);
            b = $urandom_range(0, 1) == 1;
            q = ($urandom_range(0, 5) == 0) ? ~irq_req : irq_req;
            step(r, s, 3'($urandom_range(0, 7)), b, 26'($urandom), 16'($urandom),
                 $urandom, q);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
